// File: rtl/rev_pe_pkg.sv
// Shared encodings for the reversible PE engine: FSM states, command opcodes and modes.
package rev_pe_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_START   = 2'd1;
    localparam logic [1:0] OP_CLR_ERR = 2'd2;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_MAC = 1'b1;

endpackage

// File: rtl/pe_buffer.sv
// Single-write, single-registered-read buffer; contents are never reset.
module pe_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (wen) mem_q[waddr] <= wdata;
        if (ren) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/rev_mul_w.sv
// Combinational reversible multiplier: (a,b) -> (p,g) forward and (p,g) -> (a',b') reverse.
module rev_mul_w #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]   fwd_a,
    input  logic [DATA_W-1:0]   fwd_b,
    output logic [2*DATA_W-1:0] fwd_p,
    output logic [2*DATA_W-1:0] fwd_g,
    input  logic [2*DATA_W-1:0] rev_p,
    input  logic [2*DATA_W-1:0] rev_g,
    output logic [DATA_W-1:0]   rev_a,
    output logic [DATA_W-1:0]   rev_b
);

    assign fwd_p = {{DATA_W{1'b0}}, fwd_a} * {{DATA_W{1'b0}}, fwd_b};
    // The garbage word is the operands masked by the product, so any flipped product bit
    // shows up in the recovered operands.
    assign fwd_g = {fwd_a, fwd_b} ^ fwd_p;
    assign {rev_a, rev_b} = rev_g ^ rev_p;

endmodule

// File: rtl/rev_pe_engine.sv
// Streams operand pairs through a reversible multiplier, checks each by reverse computation,
// and stores products (MUL) or running sums (MAC) for host readback.
module rev_pe_engine
    import rev_pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ACC_W  = 2*DATA_W+4,
    parameter int ERR_W  = 8,
    parameter int AW     = $clog2(DEPTH),
    parameter int LW     = $clog2(DEPTH)+1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                host_wen,
    input  logic [AW-1:0]       host_waddr,
    input  logic [2*DATA_W-1:0] host_wdata,
    input  logic                host_ren,
    input  logic [AW-1:0]       host_raddr,
    output logic [ACC_W-1:0]    host_rdata,
    output logic                host_rvalid,
    input  logic                cmd_valid,
    input  logic [1:0]          cmd_op,
    input  logic                cmd_mode,
    input  logic [LW-1:0]       cmd_len,
    input  logic                inject_fault,
    output logic                busy,
    output logic                done,
    output logic                err_sticky,
    output logic [ERR_W-1:0]    err_count,
    output logic [AW-1:0]       err_first_idx
);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    state_t              state_q, state_d;
    logic [LW-1:0]       len_q, len_d, rd_idx_q, rd_idx_d, len_eff;
    logic                mode_q, mode_d;
    logic [ACC_W-1:0]    acc_q, acc_d, p_ext;
    logic                s1_v_q, s2_v_q, s3_v_q;
    logic [AW-1:0]       s1_idx_q, s2_idx_q, s3_idx_q;
    logic [DATA_W-1:0]   s2_a_q, s2_b_q;
    logic [2*DATA_W-1:0] s2_p_q, s2_g_q;
    logic [ACC_W-1:0]    s3_res_q, s3_res_d;
    logic                err_sticky_q, err_sticky_d;
    logic [ERR_W-1:0]    err_count_q, err_count_d;
    logic [AW-1:0]       err_idx_q, err_idx_d;
    logic                rd_ok_q, rvalid_q;

    logic                idle_like, start, clr, issue, mismatch;
    logic [2*DATA_W-1:0] in_rdata, fwd_p, fwd_g;
    logic [DATA_W-1:0]   rev_a, rev_b;
    logic [ACC_W-1:0]    out_rdata;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign start     = cmd_valid && (cmd_op == OP_START) && idle_like;
    assign clr       = cmd_valid && (cmd_op == OP_CLR_ERR);
    assign len_eff   = (cmd_len > DEPTH_L) ? DEPTH_L : cmd_len;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rd_idx_d = rd_idx_q;
        mode_d   = mode_q;
        issue    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    len_d    = len_eff;
                    mode_d   = cmd_mode;
                    rd_idx_d = '0;
                    state_d  = (len_eff == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                issue    = 1'b1;
                rd_idx_d = rd_idx_q + 1'b1;
                if (rd_idx_q == len_q - 1'b1) state_d = ST_DRAIN;
            end
            default: begin
                if (!(s1_v_q || s2_v_q || s3_v_q)) state_d = ST_DONE;
            end
        endcase
    end

    pe_buffer #(.WIDTH(2*DATA_W), .DEPTH(DEPTH), .AW(AW)) u_inbuf (
        .clk   (clk),
        .wen   (host_wen && idle_like),
        .waddr (host_waddr),
        .wdata (host_wdata),
        .ren   (issue),
        .raddr (rd_idx_q[AW-1:0]),
        .rdata (in_rdata)
    );

    // The fault hook corrupts only the copy fed to the reverse check, never the stored result.
    rev_mul_w #(.DATA_W(DATA_W)) u_mul (
        .fwd_a (in_rdata[DATA_W-1:0]),
        .fwd_b (in_rdata[2*DATA_W-1:DATA_W]),
        .fwd_p (fwd_p),
        .fwd_g (fwd_g),
        .rev_p (s2_p_q ^ {{(2*DATA_W-1){1'b0}}, inject_fault}),
        .rev_g (s2_g_q),
        .rev_a (rev_a),
        .rev_b (rev_b)
    );

    assign mismatch = s2_v_q && ({rev_a, rev_b} != {s2_a_q, s2_b_q});
    assign p_ext    = ACC_W'(s2_p_q);

    always_comb begin
        acc_d    = acc_q;
        s3_res_d = p_ext;
        if (start) begin
            acc_d = '0;
        end else if (s2_v_q && (mode_q == MODE_MAC)) begin
            acc_d    = acc_q + p_ext;
            s3_res_d = acc_q + p_ext;
        end
    end

    // A mismatch in the same cycle as CLR_ERR lands on the freshly cleared state.
    always_comb begin
        err_sticky_d = clr ? 1'b0 : err_sticky_q;
        err_count_d  = clr ? '0 : err_count_q;
        err_idx_d    = clr ? '0 : err_idx_q;
        if (mismatch) begin
            if (!err_sticky_d) err_idx_d = s2_idx_q;
            if (err_count_d != '1) err_count_d = err_count_d + 1'b1;
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            rd_idx_q     <= '0;
            mode_q       <= MODE_MUL;
            acc_q        <= '0;
            s1_v_q       <= 1'b0;
            s2_v_q       <= 1'b0;
            s3_v_q       <= 1'b0;
            s1_idx_q     <= '0;
            s2_idx_q     <= '0;
            s3_idx_q     <= '0;
            s2_a_q       <= '0;
            s2_b_q       <= '0;
            s2_p_q       <= '0;
            s2_g_q       <= '0;
            s3_res_q     <= '0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
            err_idx_q    <= '0;
            rd_ok_q      <= 1'b0;
            rvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            rd_idx_q     <= rd_idx_d;
            mode_q       <= mode_d;
            acc_q        <= acc_d;
            s1_v_q       <= issue;
            s1_idx_q     <= rd_idx_q[AW-1:0];
            s2_v_q       <= s1_v_q;
            s2_idx_q     <= s1_idx_q;
            s2_a_q       <= in_rdata[DATA_W-1:0];
            s2_b_q       <= in_rdata[2*DATA_W-1:DATA_W];
            s2_p_q       <= fwd_p;
            s2_g_q       <= fwd_g;
            s3_v_q       <= s2_v_q;
            s3_idx_q     <= s2_idx_q;
            s3_res_q     <= s3_res_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
            err_idx_q    <= err_idx_d;
            rd_ok_q      <= host_ren && idle_like;
            rvalid_q     <= host_ren;
        end
    end

    pe_buffer #(.WIDTH(ACC_W), .DEPTH(DEPTH), .AW(AW)) u_outbuf (
        .clk   (clk),
        .wen   (s3_v_q),
        .waddr (s3_idx_q),
        .wdata (s3_res_q),
        .ren   (host_ren),
        .raddr (host_raddr),
        .rdata (out_rdata)
    );

    assign host_rdata    = rd_ok_q ? out_rdata : '0;
    assign host_rvalid   = rvalid_q;
    assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done          = (state_q == ST_DONE);
    assign err_sticky    = err_sticky_q;
    assign err_count     = err_count_q;
    assign err_first_idx = err_idx_q;

endmodule

// File: tb/tb_rev_pe_engine.sv
// Directed bench for rev_pe_engine: MUL/MAC results, error tracking, length clamping, reset abort.
module tb_rev_pe_engine;
    import rev_pe_pkg::*;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int ACC_W = 2*DW+4;
    localparam int ERR_W = 8;
    localparam int AW    = 4;
    localparam int LW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             host_wen;
    logic [AW-1:0]    host_waddr;
    logic [2*DW-1:0]  host_wdata;
    logic             host_ren;
    logic [AW-1:0]    host_raddr;
    logic [ACC_W-1:0] host_rdata;
    logic             host_rvalid;
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic             cmd_mode;
    logic [LW-1:0]    cmd_len;
    logic             inject_fault;
    logic             busy;
    logic             done;
    logic             err_sticky;
    logic [ERR_W-1:0] err_count;
    logic [AW-1:0]    err_first_idx;

    int tests_run    = 0;
    int tests_failed = 0;

    rev_pe_engine #(.DATA_W(DW), .DEPTH(DEPTH), .ACC_W(ACC_W), .ERR_W(ERR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .host_wen      (host_wen),
        .host_waddr    (host_waddr),
        .host_wdata    (host_wdata),
        .host_ren      (host_ren),
        .host_raddr    (host_raddr),
        .host_rdata    (host_rdata),
        .host_rvalid   (host_rvalid),
        .cmd_valid     (cmd_valid),
        .cmd_op        (cmd_op),
        .cmd_mode      (cmd_mode),
        .cmd_len       (cmd_len),
        .inject_fault  (inject_fault),
        .busy          (busy),
        .done          (done),
        .err_sticky    (err_sticky),
        .err_count     (err_count),
        .err_first_idx (err_first_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input int a, input int b);
        host_wen   = 1'b1;
        host_waddr = addr[AW-1:0];
        host_wdata = {b[DW-1:0], a[DW-1:0]};
        tick();
        host_wen   = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int addr, input int exp);
        host_ren   = 1'b1;
        host_raddr = addr[AW-1:0];
        tick();
        host_ren   = 1'b0;
        check({tag, "_rvalid"}, 32'(host_rvalid), 1);
        check(tag, 32'(host_rdata), exp);
    endtask

    task automatic clr_err();
        cmd_valid = 1'b1;
        cmd_op    = OP_CLR_ERR;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    // inj: -1 none, -2 every cycle, else element index. clr_n/busy_n/host_n: cycle after START, -1 none.
    task automatic run_job(input string tag, input logic mode, input int len, input int inj,
                           input int clr_n, input int busy_n, input int host_n, input int exp_done);
        int done_n;
        int done_cnt;
        done_n   = -1;
        done_cnt = 0;
        cmd_valid = 1'b1;
        cmd_op    = OP_START;
        cmd_mode  = mode;
        cmd_len   = len[LW-1:0];
        tick();
        for (int n = 1; n <= 30; n++) begin
            if (done) begin
                done_cnt++;
                if (done_n < 0) done_n = n;
            end
            if (host_n >= 0 && n == host_n + 1) begin
                check({tag, "_run_rvalid"}, 32'(host_rvalid), 1);
                check({tag, "_run_rdata"}, 32'(host_rdata), 0);
            end
            cmd_valid = 1'b0;
            cmd_op    = OP_NOP;
            cmd_mode  = 1'b0;
            cmd_len   = '0;
            if (n == busy_n) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_START;
                cmd_mode  = ~mode;
                cmd_len   = 5'd2;
            end
            if (n == clr_n) begin
                cmd_valid = 1'b1;
                cmd_op    = OP_CLR_ERR;
            end
            inject_fault = (inj == -2) || (inj >= 0 && n == inj + 3);
            host_ren   = (n == host_n);
            host_raddr = 4'd1;
            host_wen   = (n == host_n);
            host_waddr = 4'd0;
            host_wdata = {8'd9, 8'd9};
            tick();
        end
        inject_fault = 1'b0;
        host_ren     = 1'b0;
        host_wen     = 1'b0;
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_n, exp_done);
    endtask

    initial begin
        int dcnt;
        rst = 1'b1;
        host_wen = 1'b0; host_waddr = '0; host_wdata = '0;
        host_ren = 1'b0; host_raddr = '0;
        cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_mode = 1'b0; cmd_len = '0;
        inject_fault = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sticky", 32'(err_sticky), 0);
        check("rst_count", 32'(err_count), 0);
        check("rst_idx", 32'(err_first_idx), 0);
        check("rst_rvalid", 32'(host_rvalid), 0);
        check("rst_rdata", 32'(host_rdata), 0);
        rst = 1'b0;
        tick();

        wr(0, 3, 5);
        wr(1, 255, 255);
        wr(2, 0, 7);
        wr(3, 16, 16);
        for (int i = 4; i < DEPTH; i++) wr(i, i, i + 1);

        // MUL, four elements
        run_job("mul4", MODE_MUL, 4, -1, -1, -1, -1, 9);
        read_chk("mul_o0", 0, 15);
        read_chk("mul_o1", 1, 65025);
        read_chk("mul_o2", 2, 0);
        read_chk("mul_o3", 3, 256);
        check("mul_errcnt", 32'(err_count), 0);

        // MAC, then again to see the accumulator restart
        run_job("mac4", MODE_MAC, 4, -1, -1, -1, -1, 9);
        read_chk("mac_o0", 0, 15);
        read_chk("mac_o1", 1, 65040);
        read_chk("mac_o2", 2, 65040);
        read_chk("mac_o3", 3, 65296);
        run_job("mac4b", MODE_MAC, 4, -1, -1, -1, -1, 9);
        read_chk("mac2_o0", 0, 15);
        read_chk("mac2_o3", 3, 65296);

        // zero length: done without writes
        run_job("len0", MODE_MUL, 0, -1, -1, -1, -1, 1);
        read_chk("len0_o1", 1, 65040);
        read_chk("len0_o0", 0, 15);

        // clamped length with an ignored START while busy
        run_job("len17", MODE_MUL, DEPTH + 1, -1, -1, 3, -1, 21);
        read_chk("len17_o1", 1, 65025);
        read_chk("len17_o4", 4, 20);
        read_chk("len17_o15", 15, 240);

        // single fault on element 2
        run_job("inj2", MODE_MUL, 4, 2, -1, -1, -1, 9);
        check("inj2_count", 32'(err_count), 1);
        check("inj2_sticky", 32'(err_sticky), 1);
        check("inj2_idx", 32'(err_first_idx), 2);
        read_chk("inj2_o2", 2, 0);
        read_chk("inj2_o3", 3, 256);
        clr_err();
        check("clr_count", 32'(err_count), 0);
        check("clr_sticky", 32'(err_sticky), 0);
        check("clr_idx", 32'(err_first_idx), 0);

        // mismatch on element 1 coinciding with CLR_ERR wins over the clear
        run_job("inj3", MODE_MUL, 4, 3, -1, -1, -1, 9);
        check("inj3_idx", 32'(err_first_idx), 3);
        run_job("clrwin", MODE_MUL, 4, 1, 4, -1, -1, 9);
        check("clrwin_count", 32'(err_count), 1);
        check("clrwin_sticky", 32'(err_sticky), 1);
        check("clrwin_idx", 32'(err_first_idx), 1);
        clr_err();

        // reset while element 5 is being issued
        cmd_valid = 1'b1; cmd_op = OP_START; cmd_mode = MODE_MUL; cmd_len = 5'd16;
        tick();
        cmd_valid = 1'b0; cmd_op = OP_NOP;
        for (int n = 1; n < 6; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        dcnt = 0;
        for (int n = 0; n < 25; n++) begin
            if (done) dcnt++;
            tick();
        end
        check("abort_no_done", dcnt, 0);
        run_job("after_rst", MODE_MAC, 3, -1, -1, -1, -1, 8);
        read_chk("rst_o0", 0, 15);
        read_chk("rst_o1", 1, 65040);
        read_chk("rst_o2", 2, 65040);

        // host access during RUN is blocked
        run_job("hostrun", MODE_MUL, 16, -1, -1, -1, 2, 21);
        read_chk("hostrun_o0", 0, 15);
        run_job("hostrun2", MODE_MUL, 1, -1, -1, -1, -1, 6);
        read_chk("hostrun2_o0", 0, 15);

        // 300 faulty elements saturate the counter
        run_job("sat0", MODE_MUL, 16, -2, -1, -1, -1, 21);
        check("sat_count16", 32'(err_count), 16);
        for (int j = 1; j < 18; j++) run_job("sat", MODE_MUL, 16, -2, -1, -1, -1, 21);
        run_job("sat_last", MODE_MUL, 12, -2, -1, -1, -1, 17);
        check("sat_count", 32'(err_count), 255);
        check("sat_sticky", 32'(err_sticky), 1);
        check("sat_idx", 32'(err_first_idx), 0);
        read_chk("sat_o15", 15, 240);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
